// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Each operation is captured, executed for one settle cycle, and returned with a valid/ready response.
module alu_req_arbiter #(
    parameter int                 DATA_W  = 8,
    parameter int                 SEL_W   = 4,
    parameter logic [SEL_W-1:0]   DIV_SEL = 4'b0011,
    parameter int                 CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_grant;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic [SEL_W-1:0]   r_alu_sel;
    logic               r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_result;
    logic               r_rsp_carry;
    logic               r_rsp_err;
    logic [CNT_W-1:0]   r_op_count;
    logic               w_grant_vld;
    logic               w_grant_id;
    logic               w_idle;

    // Returns {err, carry, result}; a divide by zero overrides whatever the ALU produced.
    function automatic logic [DATA_W+1:0] f_capture(
        input logic [SEL_W-1:0]  sel,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] res,
        input logic              carry
    );
        if (sel == DIV_SEL && b == '0)
            return {1'b1, 1'b0, {DATA_W{1'b1}}};
        return {1'b0, carry, res};
    endfunction

    assign w_idle      = (r_state == S_IDLE);
    assign w_grant_vld = w_idle && (req0_valid || req1_valid);
    assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = w_grant_vld && !w_grant_id;
        req1_ready = w_grant_vld &&  w_grant_id;
        rsp_valid  = (r_state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_alu_a   <= w_grant_id ? req1_a   : req0_a;
                        r_alu_b   <= w_grant_id ? req1_b   : req0_b;
                        r_alu_sel <= w_grant_id ? req1_sel : req0_sel;
                        r_rsp_id  <= w_grant_id;
                    end
                end
                S_EXEC: begin
                    {r_rsp_err, r_rsp_carry, r_rsp_result} <=
                        f_capture(r_alu_sel, r_alu_b, alu_out, alu_carry);
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_last_grant <= r_rsp_id;
                        r_op_count   <= r_op_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_err    = r_rsp_err;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: emulates the ALU and checks every cycle against a transaction-level model.
module tb_alu_req_arbiter;

    localparam int DW = 8;
    localparam int SW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [SW-1:0] req0_sel, req1_sel;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [SW-1:0] alu_sel;
    logic          alu_carry;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
    logic [DW-1:0] rsp_result;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    alu_req_arbiter #(.DATA_W(DW), .SEL_W(SW), .DIV_SEL(4'b0011), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err), .op_count(op_count)
    );

    // Behavioural ALU: returns {carry, result}; carry is always that of A+B.
    function automatic logic [DW:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [SW-1:0] sel);
        logic [DW:0]   s;
        logic [15:0]   m;
        logic [DW-1:0] r;
        s = {1'b0, a} + {1'b0, b};
        m = a * b;
        case (sel)
            4'd0: r = s[DW-1:0];
            4'd1: r = a - b;
            4'd2: r = m[DW-1:0];
            4'd3: r = (b != 0) ? a / b : 8'hAA;
            4'd4: r = a << 1;
            4'd5: r = a >> 1;
            4'd6: r = {a[DW-2:0], a[DW-1]};
            4'd7: r = {a[0], a[DW-1:1]};
            default: r = s[DW-1:0];
        endcase
        return {s[DW], r};
    endfunction

    assign {alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_sel);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction model: at most one outstanding op, response due two edges after acceptance.
    bit            m_have, m_last, m_fresh, m_id, m_carry, m_err;
    int            m_age;
    logic [CW-1:0] m_cnt;
    logic [DW-1:0] m_a, m_b, m_res;
    logic [SW-1:0] m_sel;
    bit            acc_vld, acc_id, hs;

    task automatic step();
        bit         gv, gid;
        logic [DW:0] cr;
        #1;
        gv = 0; gid = 0;
        if (!m_have) begin
            if (req0_valid && req1_valid) begin gv = 1; gid = ~m_last; end
            else if (req0_valid)          begin gv = 1; gid = 0; end
            else if (req1_valid)          begin gv = 1; gid = 1; end
        end
        chk("req0_ready", req0_ready, gv && !gid);
        chk("req1_ready", req1_ready, gv && gid);
        chk("rsp_valid", rsp_valid, m_have && m_age >= 2);
        chk("op_count", op_count, m_cnt);
        if (m_have) begin
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_sel", alu_sel, m_sel);
        end
        if (m_have && m_age >= 2) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_carry", rsp_carry, m_carry);
            chk("rsp_err", rsp_err, m_err);
        end
        if (m_fresh) begin
            chk("reset_alu", {alu_a, alu_b, alu_sel}, 0);
            chk("reset_rsp", {rsp_id, rsp_result, rsp_carry, rsp_err}, 0);
        end
        acc_vld = 0; hs = 0;
        if (rst) begin
            m_have = 0; m_last = 1; m_cnt = 0; m_fresh = 1;
        end else if (m_have && m_age >= 2) begin
            if (rsp_ready) begin hs = 1; m_have = 0; m_last = m_id; m_cnt = m_cnt + 1'b1; end
        end else if (m_have) begin
            m_age++;
        end else if (gv) begin
            m_id  = gid;
            m_a   = gid ? req1_a   : req0_a;
            m_b   = gid ? req1_b   : req0_b;
            m_sel = gid ? req1_sel : req0_sel;
            if (m_sel == 4'b0011 && m_b == 0) begin
                m_res = 8'hFF; m_carry = 0; m_err = 1;
            end else begin
                cr = alu_f(m_a, m_b, m_sel);
                m_res = cr[DW-1:0]; m_carry = cr[DW]; m_err = 0;
            end
            m_have = 1; m_age = 1; m_fresh = 0;
            acc_vld = 1; acc_id = gid;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit id, input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [SW-1:0] sel);
        if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel; end
        else    begin req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel; end
    endtask

    task automatic wait_accept(input string tag);
        bit got;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (acc_vld) got = 1;
        end
        chk(tag, got, 1);
    endtask

    // Single directed operation with rsp_ready held high; checks the response against constants.
    task automatic run_op(input string tag, input bit id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [SW-1:0] sel, input logic [DW-1:0] er, input bit ec, input bit ee);
        drive(id, 1, a, b, sel);
        wait_accept({tag, "_accept"});
        drive(id, 0, a, b, sel);
        step();
        #1;
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_result"}, rsp_result, er);
        chk({tag, "_carry"}, rsp_carry, ec);
        chk({tag, "_err"}, rsp_err, ee);
        chk({tag, "_id"}, rsp_id, id);
        step();
    endtask

    initial begin
        bit q[$];
        rst = 1; rsp_ready = 0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        m_have = 0; m_last = 1; m_cnt = 0; m_fresh = 1; m_age = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        step();

        rsp_ready = 1;
        run_op("T1", 0, 8'h0F, 8'h01, 4'b0000, 8'h10, 0, 0);
        run_op("T2", 1, 8'hFF, 8'h01, 4'b0001, 8'hFE, 1, 0);
        #1 chk("T2_count", op_count, 2);
        run_op("T4_div0", 0, 8'h20, 8'h00, 4'b0011, 8'hFF, 0, 1);
        run_op("T4_div", 0, 8'h20, 8'h04, 4'b0011, 8'h08, 0, 0);
        run_op("op_1000", 1, 8'h80, 8'h90, 4'b1000, 8'h10, 1, 0);
        run_op("mul_trunc", 0, 8'h10, 8'h11, 4'b0010, 8'h10, 0, 0);

        // Backpressure: response held while req1 waits.
        rsp_ready = 0;
        drive(0, 1, 8'h05, 8'h07, 4'b0000);
        wait_accept("T5_accept0");
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 8'h09, 8'h03, 4'b0001);
        step();
        repeat (5) step();
        #1 chk("T5_hold_valid", rsp_valid, 1);
        chk("T5_hold_req1", req1_ready, 0);
        rsp_ready = 1;
        step();
        step();
        chk("T5_accept_next", acc_vld && acc_id, 1);
        drive(1, 0, 0, 0, 0);
        repeat (2) step();

        // Reset in EXEC discards the op.
        drive(1, 1, 8'h33, 8'h44, 4'b0000);
        wait_accept("T6_accept");
        drive(1, 0, 0, 0, 0);
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("T6_rsp_valid", rsp_valid, 0);
        chk("T6_op_count", op_count, 0);
        chk("T6_alu_a", alu_a, 0);

        // Both requesters continuously valid: grants alternate starting with req0.
        drive(0, 1, 8'h01, 8'h02, 4'b0000);
        drive(1, 1, 8'h03, 8'h04, 4'b0001);
        for (int k = 0; k < 12; k++) begin
            step();
            if (acc_vld) q.push_back(acc_id);
        end
        chk("T3_num_grants", q.size(), 4);
        for (int k = 0; k < q.size() && k < 4; k++) chk("T3_grant_order", q[k], k % 2);
        #1 chk("T3_op_count", op_count, 4);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        step();

        // Randomized traffic with holds, drops and backpressure.
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < 2; r++) begin
                bit v;
                v = r ? req1_valid : req0_valid;
                if (v && acc_vld && acc_id == r[0]) v = 0;
                if (!v && ($urandom % 3) == 0) begin
                    logic [SW-1:0] s;
                    s = ($urandom % 4 == 0) ? 4'b0011 : SW'($urandom);
                    drive(r[0], 1, DW'($urandom), ($urandom % 4 == 0) ? 8'h00 : DW'($urandom), s);
                end else if (v && ($urandom % 20) == 0) begin
                    drive(r[0], 0, 0, 0, 0);
                end else if (!v) begin
                    drive(r[0], 0, 0, 0, 0);
                end
            end
            rsp_ready = ($urandom % 4) != 0;
            step();
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rsp_ready = 1;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
